// File: rtl/pciexp_tx_sched.sv
// pciexp_tx_sched: per-lane TX symbol scheduler. Arbitrates link-layer data, TS1/TS2 training sets,
// SKP/EIOS ordered sets and the compliance pattern onto one registered symbol path (one symbol per PCLK250).
// Ports: LINK_* control levels and TS fields in; DL_* symbol stream in with combinational DL_Ready out;
// TX* registered symbol outputs plus SKP_Sent/TS_Done one-cycle pulses. Latency: decision to TX* is one cycle.
// Backpressure: DL_Ready is low whenever an ordered set owns the symbol slot; ordered sets are never interrupted.
module pciexp_tx_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_CNT_W    = 11
) (
  input  logic       PCLK250,
  input  logic       RESETN,
  input  logic       LINK_ElecIdle,
  input  logic       LINK_Compl,
  input  logic       LINK_Train,
  input  logic       LINK_TsType,
  input  logic [7:0] LINK_LinkNum,
  input  logic [7:0] LINK_LaneNum,
  input  logic [7:0] LINK_NFts,
  input  logic       DL_Valid,
  input  logic [7:0] DL_Data,
  input  logic       DL_DataK,
  output logic       DL_Ready,
  output logic [7:0] TXDATA,
  output logic       TXDATAK,
  output logic       TXELECIDLE,
  output logic       TXCOMPLIANCE,
  output logic       SKP_Sent,
  output logic       TS_Done
);

  typedef enum logic [2:0] {ST_EI, ST_DATA, ST_TS, ST_SKP, ST_EIOS, ST_COMPL} state_t;

  localparam logic [SKP_CNT_W-1:0] SKP_THR = SKP_CNT_W'(SKP_INTERVAL - 1);

  state_t               st, sel_st;
  logic [3:0]           idx, sel_idx, idx_nxt, last_idx;
  logic                 bnd, pkt_start, skp_ok;
  logic [7:0]           ts_link, ts_lane, ts_nfts;
  logic                 ts_type;
  logic [SKP_CNT_W-1:0] skp_cnt;
  logic                 skp_pending;
  logic [7:0]           sym_dat;
  logic                 sym_k, sym_ei, sym_compl, sym_skp, sym_tsd;

  // Selection: st/idx describe the last emitted symbol and the index of the next one.
  // idx==0 inside an ordered set means the previous set just completed.
  always_comb begin
    bnd       = (st == ST_EI) || (st == ST_DATA) || (idx == 4'd0);
    pkt_start = DL_DataK && ((DL_Data == 8'hFB) || (DL_Data == 8'h5C));
    // A pending SKP may only cut into the data stream between packets.
    skp_ok    = (st != ST_DATA) || !DL_Valid || pkt_start;
    sel_st    = st;
    sel_idx   = idx;
    if (bnd) begin
      sel_idx = 4'd0;
      if (st == ST_EIOS) begin
        sel_st = ST_EI;
      end else if (st == ST_EI) begin
        // Leaving idle never starts with a SKP; the pending flag is dropped instead.
        if (LINK_ElecIdle)   sel_st = ST_EI;
        else if (LINK_Compl) sel_st = ST_COMPL;
        else if (LINK_Train) sel_st = ST_TS;
        else if (DL_Valid)   sel_st = ST_DATA;
        else                 sel_st = ST_EI;
      end else begin
        if (LINK_ElecIdle)              sel_st = ST_EIOS;
        else if (skp_pending && skp_ok) sel_st = ST_SKP;
        else if (LINK_Compl)            sel_st = ST_COMPL;
        else if (LINK_Train)            sel_st = ST_TS;
        else                            sel_st = ST_DATA;
      end
    end
  end

  assign DL_Ready = (sel_st == ST_DATA) && DL_Valid;

  always_comb begin
    last_idx = (sel_st == ST_TS) ? 4'd15 : 4'd3;
    if ((sel_st == ST_EI) || (sel_st == ST_DATA)) idx_nxt = 4'd0;
    else if (sel_idx == last_idx)                 idx_nxt = 4'd0;
    else                                          idx_nxt = sel_idx + 4'd1;
  end

  // Symbol content for the selected state/index.
  always_comb begin
    sym_dat   = 8'h00;
    sym_k     = 1'b0;
    sym_ei    = 1'b0;
    sym_compl = 1'b0;
    sym_skp   = 1'b0;
    sym_tsd   = 1'b0;
    case (sel_st)
      ST_EI: sym_ei = 1'b1;
      ST_DATA: begin
        if (DL_Valid) begin
          sym_dat = DL_Data;
          sym_k   = DL_DataK;
        end
      end
      ST_TS: begin
        // Symbols 1..3 come from the fields captured when symbol 0 was chosen.
        case (sel_idx)
          4'd0:    begin sym_dat = 8'hBC;   sym_k = 1'b1; end
          4'd1:    begin sym_dat = ts_link; sym_k = (ts_link == 8'hF7); end
          4'd2:    begin sym_dat = ts_lane; sym_k = (ts_lane == 8'hF7); end
          4'd3:    sym_dat = ts_nfts;
          4'd4:    sym_dat = 8'h02;
          4'd5:    sym_dat = 8'h00;
          default: sym_dat = ts_type ? 8'h45 : 8'h4A;
        endcase
        sym_tsd = (sel_idx == 4'd15);
      end
      ST_SKP: begin
        sym_dat = (sel_idx == 4'd0) ? 8'hBC : 8'h1C;
        sym_k   = 1'b1;
        sym_skp = (sel_idx == 4'd3);
      end
      ST_EIOS: begin
        sym_dat = (sel_idx == 4'd0) ? 8'hBC : 8'h7C;
        sym_k   = 1'b1;
      end
      ST_COMPL: begin
        case (sel_idx[1:0])
          2'd0:    begin sym_dat = 8'hBC; sym_k = 1'b1; sym_compl = 1'b1; end
          2'd1:    sym_dat = 8'hB5;
          2'd2:    begin sym_dat = 8'hBC; sym_k = 1'b1; end
          default: sym_dat = 8'h4A;
        endcase
      end
      default: sym_ei = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK250 or negedge RESETN) begin
    if (!RESETN) begin
      st           <= ST_EI;
      idx          <= 4'd0;
      TXDATA       <= 8'h00;
      TXDATAK      <= 1'b0;
      TXELECIDLE   <= 1'b1;
      TXCOMPLIANCE <= 1'b0;
      SKP_Sent     <= 1'b0;
      TS_Done      <= 1'b0;
      ts_link      <= 8'h00;
      ts_lane      <= 8'h00;
      ts_nfts      <= 8'h00;
      ts_type      <= 1'b0;
      skp_cnt      <= '0;
      skp_pending  <= 1'b0;
    end else begin
      st           <= sel_st;
      idx          <= idx_nxt;
      TXDATA       <= sym_dat;
      TXDATAK      <= sym_k;
      TXELECIDLE   <= sym_ei;
      TXCOMPLIANCE <= sym_compl;
      SKP_Sent     <= sym_skp;
      TS_Done      <= sym_tsd;
      if ((sel_st == ST_TS) && (sel_idx == 4'd0)) begin
        ts_link <= LINK_LinkNum;
        ts_lane <= LINK_LaneNum;
        ts_nfts <= LINK_NFts;
        ts_type <= LINK_TsType;
      end
      // Counts transmitted (non-idle) symbols; saturates rather than wrapping.
      if ((sel_st == ST_EI) || ((sel_st == ST_SKP) && (sel_idx == 4'd0)))
        skp_cnt <= '0;
      else if (skp_cnt != '1)
        skp_cnt <= skp_cnt + SKP_CNT_W'(1);
      if (((st == ST_EI) && (sel_st != ST_EI)) || ((sel_st == ST_SKP) && (sel_idx == 4'd0)))
        skp_pending <= 1'b0;
      else if (skp_cnt >= SKP_THR)
        skp_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pciexp_tx_sched.sv
// tb_pciexp_tx_sched: directed bench for pciexp_tx_sched with a short SKP interval.
// Expected symbols are queued as stimulus is applied and compared one per cycle on the falling edge.
// Covers reset, TS1/TS2, SKP insertion, EIOS/idle, compliance, data forwarding and mid-set reset.
module tb_pciexp_tx_sched;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       ei;
    logic       c;
    logic       skp;
    logic       tsd;
  } sym_t;

  logic       PCLK250 = 1'b0;
  logic       RESETN;
  logic       LINK_ElecIdle, LINK_Compl, LINK_Train, LINK_TsType;
  logic [7:0] LINK_LinkNum, LINK_LaneNum, LINK_NFts;
  logic       DL_Valid, DL_DataK;
  logic [7:0] DL_Data;
  logic       DL_Ready;
  logic [7:0] TXDATA;
  logic       TXDATAK, TXELECIDLE, TXCOMPLIANCE, SKP_Sent, TS_Done;

  int   n_checks = 0;
  int   n_err    = 0;
  sym_t exp_q[$];

  pciexp_tx_sched #(.SKP_INTERVAL(16), .SKP_CNT_W(11)) dut (
    .PCLK250      (PCLK250),
    .RESETN       (RESETN),
    .LINK_ElecIdle(LINK_ElecIdle),
    .LINK_Compl   (LINK_Compl),
    .LINK_Train   (LINK_Train),
    .LINK_TsType  (LINK_TsType),
    .LINK_LinkNum (LINK_LinkNum),
    .LINK_LaneNum (LINK_LaneNum),
    .LINK_NFts    (LINK_NFts),
    .DL_Valid     (DL_Valid),
    .DL_Data      (DL_Data),
    .DL_DataK     (DL_DataK),
    .DL_Ready     (DL_Ready),
    .TXDATA       (TXDATA),
    .TXDATAK      (TXDATAK),
    .TXELECIDLE   (TXELECIDLE),
    .TXCOMPLIANCE (TXCOMPLIANCE),
    .SKP_Sent     (SKP_Sent),
    .TS_Done      (TS_Done)
  );

  always #5 PCLK250 = ~PCLK250;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic sym_t mk(input logic [7:0] d, input logic k, input logic ei,
                              input logic c, input logic skp, input logic tsd);
    sym_t s;
    s.d = d; s.k = k; s.ei = ei; s.c = c; s.skp = skp; s.tsd = tsd;
    return s;
  endfunction

  function automatic sym_t obs();
    return {TXDATA, TXDATAK, TXELECIDLE, TXCOMPLIANCE, SKP_Sent, TS_Done};
  endfunction

  task automatic chk_sym(input string tag, input sym_t o, input sym_t e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed d=%h k=%b ei=%b c=%b skp=%b tsd=%b expected d=%h k=%b ei=%b c=%b skp=%b tsd=%b",
             tag, o.d, o.k, o.ei, o.c, o.skp, o.tsd, e.d, e.k, e.ei, e.c, e.skp, e.tsd);
    end
  endtask

  task automatic chk_bit(input string tag, input logic o, input logic e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic push_ts(input logic [7:0] link, input logic [7:0] lane, input logic [7:0] nfts, input logic typ);
    exp_q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(link, link == 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(lane, lane == 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(nfts, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 6; i < 16; i++)
      exp_q.push_back(mk(typ ? 8'h45 : 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, i == 15));
  endtask

  task automatic push_skp();
    exp_q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic push_eios();
    exp_q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      exp_q.push_back(mk(8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_ei(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_compl();
    exp_q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // One cycle per expected entry: wait for the falling edge, pop and compare.
  task automatic drain(input int n, input string tag);
    sym_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK250);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL %s observed=output_cycle expected=no_more_symbols_queued", tag);
      end else begin
        e = exp_q.pop_front();
        chk_sym(tag, obs(), e);
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain(exp_q.size(), tag);
  endtask

  task automatic dl_step(input logic v, input logic [7:0] d, input logic k, input logic exp_rdy);
    DL_Valid = v;
    DL_Data  = d;
    DL_DataK = k;
    #1;
    chk_bit("dl_ready", DL_Ready, exp_rdy);
  endtask

  initial begin
    RESETN        = 1'b0;
    LINK_ElecIdle = 1'b0;
    LINK_Compl    = 1'b0;
    LINK_Train    = 1'b0;
    LINK_TsType   = 1'b0;
    LINK_LinkNum  = 8'hF7;
    LINK_LaneNum  = 8'h00;
    LINK_NFts     = 8'hFF;
    DL_Valid      = 1'b0;
    DL_Data       = 8'h00;
    DL_DataK      = 1'b0;

    repeat (2) @(negedge PCLK250);
    chk_sym("reset", obs(), mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    chk_bit("reset_dl_ready", DL_Ready, 1'b0);

    // TS1 back to back; with a 16-symbol interval every set is followed by a SKP.
    RESETN     = 1'b1;
    LINK_Train = 1'b1;
    push_ts(8'hF7, 8'h00, 8'hFF, 1'b0);
    push_skp();
    drain_all("ts1_first");

    // TsType flips mid-set: current set keeps TS1 ident, next set is TS2.
    push_ts(8'hF7, 8'h00, 8'hFF, 1'b0);
    drain(5, "ts1_second");
    LINK_TsType = 1'b1;
    push_skp();
    push_ts(8'hF7, 8'h00, 8'hFF, 1'b1);
    drain(22, "ts_type_switch");

    // Electrical idle mid-TS: set completes, EIOS beats the due SKP, then idle.
    LINK_ElecIdle = 1'b1;
    push_eios();
    push_ei(4);
    drain_all("elec_idle");

    // Leaving idle starts directly with a TS (pending SKP dropped).
    LINK_ElecIdle = 1'b0;
    push_ts(8'hF7, 8'h00, 8'hFF, 1'b1);
    drain(7, "ts_after_ei");

    // Reset at TS symbol 7.
    RESETN = 1'b0;
    #1;
    chk_sym("reset_async", obs(), mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.delete();
    LINK_LinkNum = 8'h01;
    LINK_LaneNum = 8'hF7;
    LINK_NFts    = 8'h1C;
    @(negedge PCLK250);
    chk_sym("reset_held", obs(), mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    RESETN = 1'b1;
    push_ts(8'h01, 8'hF7, 8'h1C, 1'b1);
    push_skp();
    drain_all("ts_restart");

    // Compliance pattern; SKP lands only on 4-symbol boundaries.
    LINK_Train = 1'b0;
    LINK_Compl = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 4; b++) push_compl();
      push_skp();
    end
    drain_all("compl");

    // Data: continuous non-K symbols keep a due SKP waiting.
    LINK_Compl = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      dl_step(1'b1, 8'(8'h10 + j), 1'b0, 1'b1);
      exp_q.push_back(mk(8'(8'h10 + j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drain(1, "dl_data");
    end

    // Packet start: SKP goes first, STP held off for four cycles.
    dl_step(1'b1, 8'hFB, 1'b1, 1'b0);
    push_skp();
    drain(1, "skp_before_stp");
    for (int j = 0; j < 3; j++) begin
      dl_step(1'b1, 8'hFB, 1'b1, 1'b0);
      drain(1, "skp_before_stp");
    end
    dl_step(1'b1, 8'hFB, 1'b1, 1'b1);
    exp_q.push_back(mk(8'hFB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drain(1, "stp_forward");

    // Logical idle.
    for (int j = 0; j < 3; j++) begin
      dl_step(1'b0, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drain(1, "logical_idle");
    end

    // Electrical idle from DATA.
    LINK_ElecIdle = 1'b1;
    push_eios();
    push_ei(2);
    drain_all("eios_from_data");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
